memory_cc: RTL
==============

MEMORY_CC -- requirements
Module: memory_cc

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the wait-state limit (1..255) used when MEMORY_CC_TIMEOUT_EN is defined.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 RegWriteM, ResultSrcM, MemWriteM  input  1 each  SHALL be the EX/MEM controls (ResultSrcM=1 means load).
REQ-005 RDM  input  5  SHALL be the destination register; ALUResultM  input  32  the address or ALU value; WriteDataM  input  32  the store data.
REQ-006 dmem_req  output  1  SHALL mean access request; dmem_we  output  1  write enable; dmem_addr  output  32  word address; dmem_wdata  output  32  store data.
REQ-007 dmem_rdata  input  32  SHALL be the load data; dmem_ack  input  1  SHALL mean access complete, sampled on the clock edge.
REQ-008 StallM  output  1  SHALL request that the IF/ID/EX/MEM stages hold.
REQ-009 RegWriteW, ResultSrcW  output  1 each; RDW  output  5; ALUResultW, ReadDataW  output  32  SHALL be the MEM/WB register outputs.
REQ-010 ResultW  output  32  SHALL be the writeback value; bus_err  output  1  SHALL be a sticky timeout flag.

Function
REQ-011 A memory op SHALL be active when MemWriteM=1 or ResultSrcM=1.
REQ-012 FSM states SHALL be IDLE and WAIT.
REQ-013 In IDLE with an active op, dmem_req SHALL assert combinationally in the same cycle.
REQ-014 In IDLE, an active op with dmem_ack=1 SHALL complete that cycle; an active op with dmem_ack=0 SHALL move the FSM to WAIT.
REQ-015 In WAIT, dmem_req SHALL stay 1; dmem_ack=1 SHALL complete the access and return the FSM to IDLE.
REQ-016 dmem_addr SHALL be {ALUResultM[31:2],2'b00}; dmem_we SHALL equal MemWriteM; dmem_wdata SHALL equal WriteDataM.
REQ-017 If MemWriteM and ResultSrcM are both 1, the op SHALL be treated as a store and ReadDataW SHALL be captured as 0.
REQ-018 StallM SHALL equal (active op AND NOT completing this cycle); upstream SHALL hold the EX/MEM inputs stable while StallM=1.
REQ-019 On the completing edge, the MEM/WB register SHALL capture the controls, RDM, ALUResultM and dmem_rdata (dmem_rdata for loads only, otherwise 0).
REQ-020 On each stalled edge, the MEM/WB register SHALL load a bubble: RegWriteW=0, ResultSrcW=0, RDW=0.
REQ-021 Non-memory ops SHALL pass into MEM/WB with 1-cycle latency and StallM=0; a zero-wait memory op SHALL also have 1-cycle latency.
REQ-022 ResultW SHALL be ReadDataW when ResultSrcW=1, otherwise ALUResultW (combinational).
REQ-023 dmem_ack received in IDLE with no active op SHALL be ignored.

Reset
REQ-024 While rst=0: FSM=IDLE, dmem_req=0, StallM=0, all W outputs=0, ResultW=0, bus_err=0, wait counter=0.
REQ-025 Reset asserted during WAIT SHALL drop dmem_req immediately and abandon the access; no MEM/WB capture SHALL occur.

Configuration
REQ-026 With MEMORY_CC_TIMEOUT_EN defined, an 8-bit counter SHALL increment each cycle in WAIT.
REQ-027 On reaching TIMEOUT_CYCLES, the access SHALL complete with ReadDataW=0 and bus_err SHALL set until reset; dmem_ack on that same cycle SHALL take priority (normal completion, no error).
REQ-028 Without MEMORY_CC_TIMEOUT_EN, WAIT SHALL persist until dmem_ack, and bus_err SHALL be tied 0.

Structure
REQ-029 Shared package riscv_pkg SHALL hold the FSM state typedef, the ResultSrc encoding and the TIMEOUT_CYCLES default.
REQ-030 The MEM/WB register SHALL be a separate sub-module, mem_wb_reg, with bubble-load and capture controls.

Verification
REQ-031 ALU op RegWriteM=1, RDM=5, ALUResultM=0x1234 -> next cycle RegWriteW=1, RDW=5, ResultW=0x1234, StallM=0.
REQ-032 Load with ALUResultM=0x103, ack same cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, ResultW=0xDEADBEEF next cycle, no stall.
REQ-033 Store with ack after 3 wait cycles -> dmem_req high for 4 cycles, StallM=1 for 3, three bubbles (RegWriteW=0) on WB, dmem_we=1 throughout.
REQ-034 Load in WAIT, rst pulsed low -> dmem_req=0 at once, all W outputs 0, FSM IDLE.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> completes after 4 WAIT cycles, ReadDataW=0, bus_err=1 and stays 1; ack on the expiry cycle -> bus_err=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the memory-stage controller
package riscv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic RESULT_SRC_ALU = 1'b0;
  localparam logic RESULT_SRC_MEM = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble-load and capture controls
module mem_wb_reg import riscv_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        capture,
  input  logic        reg_write_m,
  input  logic        result_src_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] read_data_m,
  output logic        reg_write_w,
  output logic        result_src_w,
  output logic [4:0]  rd_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w
);

  // A bubble only kills the control fields; the data fields keep their last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_w  <= 1'b0;
      result_src_w <= RESULT_SRC_ALU;
      rd_w         <= 5'd0;
      alu_result_w <= 32'd0;
      read_data_w  <= 32'd0;
    end else if (bubble) begin
      reg_write_w  <= 1'b0;
      result_src_w <= RESULT_SRC_ALU;
      rd_w         <= 5'd0;
    end else if (capture) begin
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
      alu_result_w <= alu_result_m;
      read_data_w  <= read_data_m;
    end
  end

endmodule

// File: rtl/memory_cc.sv
// rtl/memory_cc.sv - memory-stage access controller; MEMORY_CC_TIMEOUT_EN enables the wait-state timeout
module memory_cc import riscv_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [4:0]  RDM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RDW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW,
  output logic        bus_err
);

  mem_state_t  state, state_next;
  logic        mem_active;
  logic        is_load;
  logic        req;
  logic        complete;
  logic        timeout;
  logic [31:0] read_data_m;

  assign mem_active = MemWriteM | ResultSrcM;
  assign is_load    = ResultSrcM & ~MemWriteM;

  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_we    = MemWriteM;
  assign dmem_wdata = WriteDataM;

`ifdef MEMORY_CC_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       err_q;

  // An ack on the expiry cycle wins, so the timeout is qualified by !dmem_ack.
  assign timeout = (state == WAIT) && !dmem_ack && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT && !complete) ? wait_cnt + 8'd1 : 8'd0;
      if (timeout)
        err_q <= 1'b1;
    end
  end

  assign bus_err = err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Upstream holds EX/MEM stable while stalled, so in WAIT the op is known active.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_active) begin
          req = 1'b1;
          if (dmem_ack)
            complete = 1'b1;
          else
            state_next = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem_ack || timeout) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Gating with rst drops the request as soon as reset asserts, even mid-access.
  assign dmem_req = rst & req;
  assign StallM   = rst & req & ~complete;

  assign read_data_m = (is_load && !timeout) ? dmem_rdata : 32'd0;

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .bubble       (StallM),
    .capture      (~StallM),
    .reg_write_m  (RegWriteM),
    .result_src_m (ResultSrcM),
    .rd_m         (RDM),
    .alu_result_m (ALUResultM),
    .read_data_m  (read_data_m),
    .reg_write_w  (RegWriteW),
    .result_src_w (ResultSrcW),
    .rd_w         (RDW),
    .alu_result_w (ALUResultW),
    .read_data_w  (ReadDataW)
  );

  assign ResultW = (ResultSrcW == RESULT_SRC_MEM) ? ReadDataW : ALUResultW;

endmodule
